// File: rtl/alu_seq_exec.sv
// alu_seq_exec: sequential execute-stage ALU.
//   Logic ops (AND/OR/NOR/NAND) and illegal codes finish with latency 1.
//   ADD/SUB/SLT ripple through a CHUNK_W-bit adder, one chunk per clock,
//   so they finish with latency N = DATA_W/CHUNK_W.
//   Optional build macro ALU_FAST_ARITH_EN: ADD/SUB/SLT use a full-width
//   adder with latency 1, and the ARITH state is never entered.
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-low reset
//   valid_i     request valid; accepted when valid_i && ready_o
//   ready_o     high while the unit is idle
//   src1_i      operand A
//   src2_i      operand B
//   ALUCtrl_i   4-bit operation code
//   result_o    registered result
//   zero_o      result_o == 0
//   overflow_o  signed overflow (ADD/SUB only)
//   illegal_o   last accepted code was illegal
//   done_o      one-cycle pulse when result_o and the flags update
module alu_seq_exec #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [3:0]        ALUCtrl_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              overflow_o,
  output logic              illegal_o,
  output logic              done_o
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  typedef enum logic {IDLE, ARITH} state_t;

  state_t state, state_nxt;

  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // SUB and SLT both compute A + ~B + 1.
  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Two's-complement overflow of a + b_eff giving s.
  function automatic logic signed_ovf(input logic signed [DATA_W-1:0] a,
                                      input logic signed [DATA_W-1:0] b_eff,
                                      input logic signed [DATA_W-1:0] s);
    return (a[DATA_W-1] == b_eff[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Signed less-than from the A - B difference, corrected for overflow.
  function automatic logic slt_bit(input logic signed [DATA_W-1:0] s,
                                   input logic ovf);
    return s[DATA_W-1] ^ ovf;
  endfunction

  logic accept;
  assign ready_o = (state == IDLE);
  assign accept  = valid_i && ready_o;

  // ---- Stage p0: latched request ----
  logic signed [DATA_W-1:0] a_p0, b_p0, b_eff_p0, s_full_p0;
  logic [3:0] op_p0;
  logic       vld_p0;     // request waiting for the single-cycle output path
  logic       last_p0;    // final adder chunk is being summed this cycle

  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_p0  <= src1_i;
      b_p0  <= src2_i;
      op_p0 <= ALUCtrl_i;
    end
  end

  assign b_eff_p0 = is_sub(op_p0) ? ~b_p0 : b_p0;

`ifdef ALU_FAST_ARITH_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) vld_p0 <= 1'b0;
    else        vld_p0 <= accept;
  end

  assign s_full_p0 = a_p0 + b_eff_p0 + DATA_W'(is_sub(op_p0));
  assign last_p0   = 1'b0;

  always_comb begin
    state_nxt = IDLE;
  end
`else
  localparam int N     = DATA_W / CHUNK_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [CNT_W-1:0]  cnt_p0;
  logic              carry_p0;
  logic [DATA_W-1:0] sum_acc_p0;
  logic [CHUNK_W:0]  chunk_sum_p0;
  int                base_p0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) vld_p0 <= 1'b0;
    else        vld_p0 <= accept && !is_arith(ALUCtrl_i);
  end

  always_comb begin
    base_p0      = int'(cnt_p0) * CHUNK_W;
    chunk_sum_p0 = {1'b0, a_p0[base_p0 +: CHUNK_W]}
                 + {1'b0, b_eff_p0[base_p0 +: CHUNK_W]}
                 + {{CHUNK_W{1'b0}}, carry_p0};
    // Lower chunks come from the accumulator; the top chunk is still in flight.
    s_full_p0    = sum_acc_p0;
    s_full_p0[base_p0 +: CHUNK_W] = chunk_sum_p0[CHUNK_W-1:0];
  end

  assign last_p0 = (state == ARITH) && (cnt_p0 == CNT_W'(N - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_p0   <= '0;
      carry_p0 <= 1'b0;
    end else if (accept) begin
      cnt_p0   <= '0;
      carry_p0 <= is_sub(ALUCtrl_i);
    end else if (state == ARITH) begin
      cnt_p0   <= last_p0 ? '0 : cnt_p0 + 1'b1;
      carry_p0 <= chunk_sum_p0[CHUNK_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == ARITH) sum_acc_p0[base_p0 +: CHUNK_W] <= chunk_sum_p0[CHUNK_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_arith(ALUCtrl_i)) state_nxt = ARITH;
      ARITH:   if (last_p0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- Stage p1: result and flag registers ----
  logic [DATA_W-1:0] res_nxt;
  logic              ovf_nxt, ill_nxt, ovf_raw, out_en;

  assign ovf_raw = signed_ovf(a_p0, b_eff_p0, s_full_p0);
  assign out_en  = vld_p0 || last_p0;

  always_comb begin
    res_nxt = '0;
    ovf_nxt = 1'b0;
    ill_nxt = 1'b0;
    case (op_p0)
      OP_AND:  res_nxt = a_p0 & b_p0;
      OP_OR:   res_nxt = a_p0 | b_p0;
      OP_NOR:  res_nxt = ~(a_p0 | b_p0);
      OP_NAND: res_nxt = ~(a_p0 & b_p0);
      OP_ADD, OP_SUB: begin
        res_nxt = s_full_p0;
        ovf_nxt = ovf_raw;
      end
      OP_SLT:  res_nxt = {{(DATA_W-1){1'b0}}, slt_bit(s_full_p0, ovf_raw)};
      default: ill_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_o   <= '0;
      zero_o     <= 1'b0;
      overflow_o <= 1'b0;
      illegal_o  <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= out_en;
      if (out_en) begin
        result_o   <= res_nxt;
        zero_o     <= (res_nxt == '0);
        overflow_o <= ovf_nxt;
        illegal_o  <= ill_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

  localparam int DW = 32;
`ifdef ALU_FAST_ARITH_EN
  localparam int ALAT = 1;
`else
  localparam int ALAT = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic          ready;
  logic [DW-1:0] src1, src2, result;
  logic [3:0]    ctrl;
  logic          zero, ovf, ill, done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_exec #(.DATA_W(DW), .CHUNK_W(8)) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(ready),
    .src1_i(src1), .src2_i(src2), .ALUCtrl_i(ctrl),
    .result_o(result), .zero_o(zero), .overflow_o(ovf),
    .illegal_o(ill), .done_o(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_arith(input logic [3:0] op);
    return op == 4'b0010 || op == 4'b0110 || op == 4'b0111;
  endfunction

  // Reference: plain signed arithmetic on wide integers.
  task automatic model(input logic [3:0] op, input logic [DW-1:0] a, b,
                       output logic [DW-1:0] r, output logic o, output logic il);
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; o = 1'b0; il = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b1101: r = ~(a & b);
      4'b0010: begin t = sa + sb; r = a + b; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'b0110: begin t = sa - sb; r = a - b; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: il = 1'b1;
    endcase
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a, b);
    logic [DW-1:0] er;
    logic eo, ei;
    int lat, exp_lat;
    bit got, ready_ok;
    model(op, a, b, er, eo, ei);
    exp_lat = is_arith(op) ? ALAT : 1;
    @(negedge clk);
    valid = 1'b1; ctrl = op; src1 = a; src2 = b;
    @(posedge clk);
    #1;
    valid = 1'b0; ctrl = 4'($urandom); src1 = $urandom; src2 = $urandom;
    got = 1'b0; ready_ok = 1'b1; lat = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      if (!ready && i > 1) ready_ok = ready_ok; // ready checked below
      if (ready !== 1'b0 && exp_lat > 1) ready_ok = 1'b0;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin got = 1'b1; lat = i; end
    end
    chk({tag, ".done_seen"}, 64'(got), 64'd1);
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".ready_busy"}, 64'(ready_ok), 64'd1);
    chk({tag, ".result"}, 64'(result), 64'(er));
    chk({tag, ".zero"}, 64'(zero), 64'(er == '0));
    chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
    chk({tag, ".ill"}, 64'(ill), 64'(ei));
    chk({tag, ".ready_done"}, 64'(ready), 64'd1);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [3:0] ops [9];
    logic [DW-1:0] corner [6];
    logic [DW-1:0] ra, rb;
    bit seen;
    ops    = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1111, 4'b0011};
    corner = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h000000FF};
    rst_n = 1'b0; valid = 1'b0; ctrl = '0; src1 = '0; src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 64'(ready), 64'd1);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.flags", 64'({zero, ovf, ill}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add5_7", 4'b0010, 32'd5, 32'd7);
    do_op("sub_ovf", 4'b0110, 32'h80000000, 32'd1);
    do_op("sub_eq", 4'b0110, 32'h1234, 32'h1234);
    do_op("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'd1);
    do_op("slt_ovf", 4'b0111, 32'h7FFFFFFF, 32'h80000000);
    do_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'd1);
    do_op("add_carry", 4'b0010, 32'h00FF00FF, 32'h00010001);
    do_op("illegal", 4'b1111, 32'h55, 32'hAA);
    do_op("and_after_ill", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00);

    // Back-to-back single-cycle ops.
    @(negedge clk);
    valid = 1'b1; ctrl = 4'b1100; src1 = '0; src2 = '0;
    @(posedge clk);
    #1;
    ctrl = 4'b1101; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("b2b.done1", 64'(done), 64'd1);
    chk("b2b.res1", 64'(result), 64'hFFFFFFFF);
    @(posedge clk);
    #1;
    chk("b2b.done2", 64'(done), 64'd1);
    chk("b2b.res2", 64'(result), 64'd0);
    chk("b2b.zero2", 64'(zero), 64'd1);
    @(posedge clk);
    #1;
    chk("b2b.done3", 64'(done), 64'd0);

    // Reset two cycles into an ADD aborts it.
    @(negedge clk);
    valid = 1'b1; ctrl = 4'b0010; src1 = 32'd9; src2 = 32'd9;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.ready", 64'(ready), 64'd1);
    chk("abort.out", 64'({result, zero, ovf, ill, done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("abort.no_done", 64'(seen), 64'd0);
    do_op("readd1_1", 4'b0010, 32'd1, 32'd1);

    // Randomized ops with corner-biased operands.
    for (int k = 0; k < 60; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      do_op("rand", ops[$urandom_range(0, 8)], ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
